dma_cfg_sequencer: RTL
======================

Name: dma_cfg_sequencer

Overview:
- Upstream command stage for the AXI-Lite single-write controller.
- Accepts one DMA transfer command: source address, destination address, length and channel enables.
- Expands the command into an ordered list of AXI-Lite register writes for an AXI DMA core, using the controller's lite_valid/lite_end handshake.
- Reports completion, or error on an illegal command or a lost write.

Parameters:
- LEN_W, 26, width of cmd_len; zero-extended to 32 bits when written.
- TIMEOUT, 1024, cycles allowed in WAIT_END before the command is aborted; must be >= 16.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE
- cmd_src_addr  in  32  MM2S source address
- cmd_dst_addr  in  32  S2MM destination address
- cmd_len  in  LEN_W  byte count for each enabled channel
- cmd_mode  in  2  bit0 = MM2S enable, bit1 = S2MM enable
- lite_awaddr  out  10  register offset to the write controller
- lite_wdata  out  32  register data to the write controller
- lite_valid  out  1  one-cycle start pulse to the write controller
- lite_end  in  1  one-cycle completion pulse from the write controller
- busy  out  1  high in every state except IDLE
- cfg_done  out  1  one-cycle pulse: all writes completed
- cfg_err  out  1  one-cycle pulse: command rejected or timed out

Behaviour:
- Reset values:
  - state IDLE; cmd_ready=1.
  - lite_valid, busy, cfg_done, cfg_err all 0.
  - lite_awaddr=0, lite_wdata=0; step index 0; timeout counter 0.
- Accept:
  - A command is accepted in cycle T when cmd_valid && cmd_ready.
  - All command fields are registered at T. Inputs are don't-care afterwards.
- Rejection:
  - Triggered by cmd_len==0 or cmd_mode==2'b00 at acceptance.
  - Next state is ERR: cfg_err=1 for one cycle at T+1, no lite_valid, then IDLE.
- Write list, fixed order, disabled channel's steps skipped:
  - S2MM (bit1):
    - S0: 0x030 <- 0x00000001
    - S1: 0x048 <- dst
    - S2: 0x058 <- len
  - MM2S (bit0):
    - S3: 0x000 <- 0x00000001
    - S4: 0x018 <- src
    - S5: 0x028 <- len
  - Length is always the last write of each channel.
  - S2MM is programmed before MM2S.
- States: IDLE -> ISSUE -> WAIT_END -> (ISSUE | DONE | ERR) -> IDLE.
- ISSUE:
  - Exactly one cycle: lite_valid=1, lite_awaddr/lite_wdata set to the current step.
  - Next state WAIT_END.
  - The first ISSUE is at T+1.
- Output hold: lite_awaddr and lite_wdata stay stable from ISSUE until lite_end is received for that step.
- lite_valid must never be high for two consecutive cycles; the write controller re-triggers on a held level.
- WAIT_END:
  - Timeout counter increments each cycle; it is cleared on entry.
  - lite_end at cycle E with more steps left: advance to the next enabled step and go to ISSUE at E+1.
  - lite_end at cycle E on the last step: go to DONE. cfg_done=1 at E+1, IDLE and cmd_ready=1 at E+2.
  - Counter reaching TIMEOUT-1 without lite_end: go to ERR. cfg_err=1 for one cycle, then IDLE; remaining steps abandoned.
  - lite_end and timeout in the same cycle: lite_end wins.
- lite_end outside WAIT_END (IDLE, ISSUE, DONE, ERR) is ignored, including a late pulse after a timeout.
- cfg_done and cfg_err are never high together.
- busy=1 in ISSUE, WAIT_END, DONE and ERR.
- Width rule: cmd_len is zero-extended from LEN_W to 32 bits; no other arithmetic.
- rst mid-operation: immediate return to the reset values; the pending write is abandoned. The system resets the write controller on the same rst.

Test Plan:
- Mode 2'b11, src=0x1000_0000, dst=0x2000_0000, len=0x100, lite_end 4 cycles after each lite_valid.
  - Required: exactly 6 lite_valid pulses, in order 0x030/1, 0x048/0x20000000, 0x058/0x100, 0x000/1, 0x018/0x10000000, 0x028/0x100.
  - Required: cfg_done one cycle after the 6th lite_end; cmd_ready high the cycle after that.
- Mode 2'b01, len=0x3FFFFFF.
  - Required: only the 0x000, 0x018 and 0x028 writes; the 0x028 data is 0x03FFFFFF; cfg_done pulses.
- cmd_len=0 or mode=2'b00 accepted at T.
  - Required: cfg_err=1 at T+1, no lite_valid, cmd_ready=1 at T+2.
- lite_end withheld on the second write.
  - Required: cfg_err after TIMEOUT cycles in WAIT_END, no further lite_valid.
  - Required: a lite_end injected later is ignored; the next command runs normally.
- cmd_valid held high through a whole command.
  - Required: second command accepted only in the cycle IDLE is re-entered.
  - Required: lite_valid is never high two cycles in a row.
- rst asserted in WAIT_END.
  - Required: next cycle all outputs at reset values and cmd_ready=1.

Source files
------------

// File: rtl/dma_cfg_sequencer.sv
// Expands one DMA transfer command into the ordered AXI-Lite register writes
// for an AXI DMA core, pacing each write on the controller's lite_valid/lite_end handshake.
module dma_cfg_sequencer #(
  parameter int unsigned LEN_W   = 26,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src_addr,
  input  logic [31:0]      cmd_dst_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode,
  output logic [9:0]       lite_awaddr,
  output logic [31:0]      lite_wdata,
  output logic             lite_valid,
  input  logic             lite_end,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mm2s_q, mm2s_d;
  logic [2:0]         step_q, step_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               last_step_s;
  logic [2:0]         next_step_s;

  logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic               lite_valid_q, lite_valid_d, cfg_done_q, cfg_done_d, cfg_err_q, cfg_err_d;
  logic [9:0]         lite_awaddr_q, lite_awaddr_d;
  logic [31:0]        lite_wdata_q, lite_wdata_d;

  // Steps 0..2 program S2MM, 3..5 program MM2S; length is the last write of each channel.
  function automatic logic [9:0] step_addr(input logic [2:0] step);
    case (step)
      3'd0:    return 10'h030;
      3'd1:    return 10'h048;
      3'd2:    return 10'h058;
      3'd3:    return 10'h000;
      3'd4:    return 10'h018;
      3'd5:    return 10'h028;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [31:0] step_data(input logic [2:0] step, input logic [31:0] src,
                                            input logic [31:0] dst, input logic [31:0] len);
    case (step)
      3'd0, 3'd3: return 32'h0000_0001;
      3'd1:       return dst;
      3'd2, 3'd5: return len;
      3'd4:       return src;
      default:    return 32'h0000_0000;
    endcase
  endfunction

  // An S2MM-only command ends after step 2; otherwise step 2 falls through into MM2S.
  assign last_step_s = (step_q == 3'd5) || ((step_q == 3'd2) && !mm2s_q);
  assign next_step_s = step_q + 3'd1;

  // State and command-datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      len_q   <= '0;
      mm2s_q  <= 1'b0;
      step_q  <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mm2s_q  <= mm2s_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    mm2s_d  = mm2s_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_src_addr;
          dst_d  = cmd_dst_addr;
          len_d  = cmd_len;
          mm2s_d = cmd_mode[0];
          if ((cmd_len == '0) || (cmd_mode == 2'b00)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_ISSUE;
            step_d  = cmd_mode[1] ? 3'd0 : 3'd3;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        // lite_end takes priority over a timeout expiring in the same cycle.
        if (lite_end) begin
          if (last_step_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            step_d  = next_step_s;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they come straight off flops.
  always_comb begin
    cmd_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    lite_valid_d  = (state_d == S_ISSUE);
    cfg_done_d    = (state_d == S_DONE);
    cfg_err_d     = (state_d == S_ERR);
    lite_awaddr_d = lite_awaddr_q;
    lite_wdata_d  = lite_wdata_q;
    if (state_d == S_ISSUE) begin
      lite_awaddr_d = step_addr(step_d);
      lite_wdata_d  = step_data(step_d, src_d, dst_d, 32'(len_d));
    end else begin
      lite_awaddr_d = lite_awaddr_q;
      lite_wdata_d  = lite_wdata_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      lite_valid_q  <= 1'b0;
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      lite_awaddr_q <= 10'h000;
      lite_wdata_q  <= 32'h0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      lite_valid_q  <= lite_valid_d;
      cfg_done_q    <= cfg_done_d;
      cfg_err_q     <= cfg_err_d;
      lite_awaddr_q <= lite_awaddr_d;
      lite_wdata_q  <= lite_wdata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign lite_valid  = lite_valid_q;
  assign cfg_done    = cfg_done_q;
  assign cfg_err     = cfg_err_q;
  assign lite_awaddr = lite_awaddr_q;
  assign lite_wdata  = lite_wdata_q;

endmodule
